aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 125 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_round_ctrl
//   Sequences one AES-128 block encryption through an external
//   sub_bytes -> shift_rows -> mix_columns datapath. The controller owns the
//   128-bit state register and the round counter. It selects the round key
//   index and folds the returned datapath result back into the state with
//   AddRoundKey (XOR).
//
//   State table:
//     state | meaning
//     IDLE  | waiting for i_start; o_key_idx=0 so the key store presents key 0
//     ROUND | one cipher round per cycle, rnd = 1..NUM_ROUNDS
//     HOLD  | ciphertext presented on o_ciphertext/o_valid until i_ready
//
// Ports:
//   clk            system clock, rising edge
//   n_rst          asynchronous active-low reset
//   i_start        begin one block (accepted in IDLE only)
//   i_plaintext    plaintext block, byte 0 in [127:120]
//   i_round_key    round key for o_key_idx, same cycle
//   o_key_idx      round key index requested this cycle
//   o_state        current state register, drives the external datapath
//   i_sr_data      shift_rows(sub_bytes(o_state)), used in the last round
//   i_mc_data      mix_columns(shift_rows(sub_bytes(o_state))), rounds 1..N-1
//   o_busy         high in ROUND and HOLD
//   o_valid        ciphertext available (HOLD)
//   i_ready        downstream accepts the ciphertext
//   o_ciphertext   result block, zero whenever o_valid is low
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_start,
    input  logic [127:0] i_plaintext,
    input  logic [127:0] i_round_key,
    output logic [3:0]   o_key_idx,
    output logic [127:0] o_state,
    input  logic [127:0] i_sr_data,
    input  logic [127:0] i_mc_data,
    output logic         o_busy,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_ciphertext
);

    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] st_q, st_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            st_q    <= st_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        st_d         = st_q;
        o_key_idx    = 4'd0;
        o_busy       = 1'b0;
        o_valid      = 1'b0;
        o_ciphertext = '0;

        case (state_q)
            S_IDLE: begin
                // Key 0 is on i_round_key here, giving the initial AddRoundKey.
                if (i_start) begin
                    st_d    = i_plaintext ^ i_round_key;
                    rnd_d   = 4'd1;
                    state_d = S_ROUND;
                end
            end

            S_ROUND: begin
                o_busy    = 1'b1;
                o_key_idx = rnd_q;
                if (rnd_q < LAST_RND) begin
                    st_d  = i_mc_data ^ i_round_key;
                    rnd_d = rnd_q + 4'd1;
                end else begin
                    // Final round skips MixColumns; rnd stays at NUM_ROUNDS.
                    st_d    = i_sr_data ^ i_round_key;
                    state_d = S_HOLD;
                end
            end

            S_HOLD: begin
                o_busy       = 1'b1;
                o_valid      = 1'b1;
                o_ciphertext = st_q;
                // A start arriving with i_ready is dropped: IDLE is only
                // reached after this edge, so the next accept is one cycle later.
                if (i_ready) begin
                    rnd_d   = 4'd0;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                rnd_d   = 4'd0;
            end
        endcase
    end

    assign o_state = st_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

    localparam int NR = 10;
    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_ARK = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         i_start;
    logic [127:0] i_plaintext;
    logic [127:0] i_round_key;
    logic [3:0]   o_key_idx;
    logic [127:0] o_state;
    logic [127:0] i_sr_data;
    logic [127:0] i_mc_data;
    logic         o_busy;
    logic         o_valid;
    logic         i_ready;
    logic [127:0] o_ciphertext;

    int checks   = 0;
    int failures = 0;

    aes_round_ctrl #(.NUM_ROUNDS(NR)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_start     (i_start),
        .i_plaintext (i_plaintext),
        .i_round_key (i_round_key),
        .o_key_idx   (o_key_idx),
        .o_state     (o_state),
        .i_sr_data   (i_sr_data),
        .i_mc_data   (i_mc_data),
        .o_busy      (o_busy),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ciphertext(o_ciphertext)
    );

    always #5 clk = ~clk;

    // ---------------- AES software reference ----------------
    logic [7:0]   sbox_t [256];
    logic [127:0] rk_t   [16];
    logic         tbl_ok = 1'b0;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] gb(input logic [127:0] s, input int n);
        return s[127-8*n -: 8];
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox_t[gb(s, n)];
        return o;
    endfunction

    // Byte n sits at row n%4, column n/4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
            o[127-8*(4*c)   -: 8] = gmul(a0,2) ^ gmul(a1,3) ^ a2 ^ a3;
            o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1,2) ^ gmul(a2,3) ^ a3;
            o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2,2) ^ gmul(a3,3);
            o[127-8*(4*c+3) -: 8] = gmul(a0,3) ^ a1 ^ a2 ^ gmul(a3,2);
        end
        return o;
    endfunction

    // State after the initial AddRoundKey and n full rounds.
    function automatic logic [127:0] aes_rounds(input logic [127:0] pt, input int n);
        logic [127:0] s;
        s = pt ^ rk_t[0];
        for (int r = 1; r <= n; r++) s = mix_columns(shift_rows(sub_bytes(s))) ^ rk_t[r];
        return s;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] pt);
        return shift_rows(sub_bytes(aes_rounds(pt, NR - 1))) ^ rk_t[NR];
    endfunction

    task automatic build_tables();
        logic [7:0]  inv, rc;
        logic [31:0] w [44];
        logic [31:0] t;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv,1) ^ rotl8(inv,2) ^ rotl8(inv,3) ^ rotl8(inv,4) ^ 8'h63;
        end
        for (int i = 0; i < 4; i++) w[i] = C1_KEY[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_t[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // External key store and datapath around the controller.
    always @(o_state or o_key_idx or tbl_ok) begin
        i_round_key = rk_t[o_key_idx];
        i_sr_data   = shift_rows(sub_bytes(o_state));
        i_mc_data   = mix_columns(i_sr_data);
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction model: m_k = 0 idle, 1..NR executing round m_k, NR+1 holding.
    int           m_k = 0;
    logic [127:0] m_pt = '0;
    logic [127:0] m_idle_st = '0;
    logic         cmp_en = 1'b0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_k = 0;
            m_idle_st = '0;
        end else if (m_k == 0) begin
            if (i_start) begin
                m_pt = i_plaintext;
                m_k  = 1;
            end
        end else if (m_k <= NR) begin
            m_k = m_k + 1;
        end else if (i_ready) begin
            m_idle_st = aes_encrypt(m_pt);
            m_k = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            if (m_k == 0) begin
                chk("m_busy",  128'(o_busy), 128'(0));
                chk("m_valid", 128'(o_valid), 128'(0));
                chk("m_ct",    o_ciphertext, '0);
                chk("m_kidx",  128'(o_key_idx), 128'(0));
                chk("m_state", o_state, m_idle_st);
            end else if (m_k <= NR) begin
                chk("m_busy",  128'(o_busy), 128'(1));
                chk("m_valid", 128'(o_valid), 128'(0));
                chk("m_ct",    o_ciphertext, '0);
                chk("m_kidx",  128'(o_key_idx), 128'(m_k));
                chk("m_state", o_state, aes_rounds(m_pt, m_k - 1));
            end else begin
                chk("m_busy",  128'(o_busy), 128'(1));
                chk("m_valid", 128'(o_valid), 128'(1));
                chk("m_ct",    o_ciphertext, aes_encrypt(m_pt));
                chk("m_kidx",  128'(o_key_idx), 128'(0));
                chk("m_state", o_state, aes_encrypt(m_pt));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        int edges;
        int last;
        int npulse;
        n_rst = 1'b0; i_start = 1'b0; i_ready = 1'b0; i_plaintext = '0;
        build_tables();
        tbl_ok = 1'b1;

        chk("pin_ark", aes_rounds(C1_PT, 0), C1_ARK);
        chk("pin_ct",  aes_encrypt(C1_PT), C1_CT);

        #1;
        chk("rst_busy",  128'(o_busy), 128'(0));
        chk("rst_valid", 128'(o_valid), 128'(0));
        chk("rst_state", o_state, '0);
        chk("rst_kidx",  128'(o_key_idx), 128'(0));
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 n_rst = 1'b1;

        // C.1 run with key index trace and a long HOLD.
        @(posedge clk); #2;
        i_plaintext = C1_PT; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        chk("c1_ark",  o_state, C1_ARK);
        chk("c1_kidx", 128'(o_key_idx), 128'(1));
        for (int r = 2; r <= NR; r++) begin
            @(posedge clk); #1;
            chk("c1_kidx", 128'(o_key_idx), 128'(r));
            chk("c1_novalid", 128'(o_valid), 128'(0));
        end
        @(posedge clk); #1;
        chk("c1_valid", 128'(o_valid), 128'(1));
        chk("c1_ct",    o_ciphertext, C1_CT);
        chk("c1_hold_kidx", 128'(o_key_idx), 128'(0));
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hold_ct",    o_ciphertext, C1_CT);
            chk("hold_valid", 128'(o_valid), 128'(1));
            #1 i_start = (i % 5 == 2);
        end
        i_start = 1'b1; i_ready = 1'b1;
        @(posedge clk); #1;
        chk("rel_valid", 128'(o_valid), 128'(0));
        chk("rel_ct",    o_ciphertext, '0);
        chk("rel_busy",  128'(o_busy), 128'(0));
        @(posedge clk); #1;
        chk("restart_busy", 128'(o_busy), 128'(1));
        chk("restart_kidx", 128'(o_key_idx), 128'(1));
        #1 i_start = 1'b0; i_ready = 1'b0;

        // Reset in round 5.
        guard = 0;
        while (o_key_idx != 4'd5 && guard < 30) begin
            @(posedge clk); #2;
            guard++;
        end
        if (guard >= 30) chk("wait_rnd5_timeout", 128'(o_key_idx), 128'(5));
        n_rst = 1'b0;
        #1;
        chk("arst_busy",  128'(o_busy), 128'(0));
        chk("arst_valid", 128'(o_valid), 128'(0));
        chk("arst_ct",    o_ciphertext, '0);
        chk("arst_kidx",  128'(o_key_idx), 128'(0));
        chk("arst_state", o_state, '0);
        @(posedge clk); #2 n_rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("post_rst_idle", 128'(o_busy), 128'(0));
        end

        // Fresh C.1 run, latency counted from the start edge.
        #1 i_plaintext = C1_PT; i_start = 1'b1; i_ready = 1'b1;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) i_start = 1'b0;
        end while (!o_valid && edges < 30);
        chk("fresh_latency", 128'(edges), 128'(11));
        chk("fresh_ct", o_ciphertext, C1_CT);

        // Back-to-back with start and ready held high.
        @(posedge clk); #2;
        i_start = 1'b1; i_ready = 1'b1;
        last = -1; npulse = 0;
        for (int c = 0; c < 62; c++) begin
            @(posedge clk); #1;
            if (o_valid) begin
                npulse++;
                chk("b2b_ct", o_ciphertext, C1_CT);
                if (last >= 0) chk("b2b_period", 128'(c - last), 128'(12));
                last = c;
            end
        end
        chk("b2b_pulses_ge4", 128'(npulse >= 4), 128'(1));

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #2;
            n_rst       = ($urandom_range(0, 149) != 0);
            i_start     = ($urandom_range(0, 2) == 0);
            i_ready     = ($urandom_range(0, 1) == 0);
            i_plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        @(posedge clk); #2;
        n_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("end_idle", 128'(o_busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
